// File: rtl/store_merge_buffer.sv
// store_merge_buffer
//
// Byte-lane store buffer between the memory stage and the data cache.
// Entries live in a circular FIFO (head/tail/count). Each entry holds a word
// address, lane-positioned data, a byte mask, the ROB id of its store and a
// committed flag. Committed entries always form a prefix starting at head.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   store, tlb_exception     allocate request / allocation suppress
//   physical_address         store address, or load address when store=0
//   op_size                  0=byte, 1=half, 2/3=word
//   store_value              right-aligned store data
//   input_rob_id             ROB id of the allocating store
//   commit, commit_rob_id    ROB commit permission for one store
//   flush                    discard every uncommitted entry
//   cache_ack                cache accepted the presented head entry
//   cache_valid/address/data/byte_mask   drain request (valid/ack)
//   full, empty              occupancy, from the pre-edge count
//   bypass_needed/possible/value         load forwarding results
//
// Drain handshake: cache_valid is high while the head entry is committed;
// address/data/mask stay stable until the edge where cache_valid and
// cache_ack are both high, which retires the head. cache_ack without
// cache_valid has no effect.
//
// Optional feature, macro STORE_BUFFER_COALESCE_EN: a store to the same word
// as the youngest, still uncommitted entry merges into it (new data wins,
// masks OR-ed, rob_id replaced) instead of allocating a new entry.
module store_merge_buffer #(
    parameter int N               = 8,
    parameter int WORD_SIZE       = 32,
    parameter int WIDTH           = 32,
    parameter int ROB_ENTRY_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       store,
    input  logic                       tlb_exception,
    input  logic [WIDTH-1:0]           physical_address,
    input  logic [1:0]                 op_size,
    input  logic [WORD_SIZE-1:0]       store_value,
    input  logic [ROB_ENTRY_WIDTH-1:0] input_rob_id,
    input  logic                       commit,
    input  logic [ROB_ENTRY_WIDTH-1:0] commit_rob_id,
    input  logic                       flush,
    input  logic                       cache_ack,
    output logic                       cache_valid,
    output logic [WIDTH-1:0]           cache_address,
    output logic [WORD_SIZE-1:0]       cache_data,
    output logic [WORD_SIZE/8-1:0]     cache_byte_mask,
    output logic                       full,
    output logic                       empty,
    output logic                       bypass_needed,
    output logic                       bypass_possible,
    output logic [WORD_SIZE-1:0]       bypass_value
);
    localparam int BYTES = WORD_SIZE / 8;
    localparam int OFFW  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int AW    = WIDTH - OFFW;
    localparam int PTRW  = $clog2(N);
    localparam int CNTW  = PTRW + 1;

    // Lane offset: half-words are forced to an even lane.
    function automatic logic [OFFW-1:0] eff_off(input logic [1:0] size, input logic [OFFW-1:0] a);
        logic [OFFW-1:0] o;
        o = a;
        if (size == 2'd1) o[0] = 1'b0;
        return o;
    endfunction

    function automatic logic [BYTES-1:0] lane_mask(input logic [1:0] size, input logic [OFFW-1:0] off);
        logic [BYTES-1:0] base;
        case (size)
            2'd0:    base = BYTES'(1);
            2'd1:    base = BYTES'(3);
            default: base = {BYTES{1'b1}};
        endcase
        return base << off;
    endfunction

    function automatic logic [WORD_SIZE-1:0] expand(input logic [BYTES-1:0] m);
        logic [WORD_SIZE-1:0] bits;
        for (int b = 0; b < BYTES; b++) bits[b*8 +: 8] = {8{m[b]}};
        return bits;
    endfunction

    logic [AW-1:0]              addr_q [N];
    logic [WORD_SIZE-1:0]       data_q [N];
    logic [BYTES-1:0]           mask_q [N];
    logic [ROB_ENTRY_WIDTH-1:0] rob_q  [N];
    logic [N-1:0]               comm_q, comm_d, comm_after;
    logic [PTRW-1:0]            head_q, head_d, tail_q, tail_d, yidx, commit_idx;
    logic [CNTW-1:0]            count_q, count_d, ccount;

    logic [OFFW-1:0]      req_off;
    logic [BYTES-1:0]     req_mask;
    logic [AW-1:0]        req_waddr;
    logic [WORD_SIZE-1:0] st_data, fwd_lanes;
    logic [BYTES-1:0]     fwd_found, fwd_hit;
    logic                 drain, commit_hit, store_ok, merge, alloc;

    assign req_waddr = physical_address[WIDTH-1:OFFW];
    assign req_off   = eff_off(op_size, physical_address[OFFW-1:0]);
    assign req_mask  = lane_mask(op_size, req_off);
    // Data outside the written lanes is kept at zero.
    assign st_data   = (store_value << {req_off, 3'b000}) & expand(req_mask);

    assign full        = (count_q == CNTW'(N));
    assign empty       = (count_q == '0);
    assign cache_valid = !empty && comm_q[head_q];
    assign drain       = cache_valid && cache_ack;
    assign yidx        = tail_q - PTRW'(1);

    assign cache_address   = cache_valid ? {addr_q[head_q], {OFFW{1'b0}}} : '0;
    assign cache_data      = cache_valid ? data_q[head_q] : '0;
    assign cache_byte_mask = cache_valid ? mask_q[head_q] : '0;

    // Oldest valid entry with a matching ROB id (scan young to old, last hit wins).
    always_comb begin
        commit_hit = 1'b0;
        commit_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (CNTW'(i) < count_q && rob_q[head_q + PTRW'(i)] == commit_rob_id) begin
                commit_hit = 1'b1;
                commit_idx = head_q + PTRW'(i);
            end
        end
    end

    always_comb begin
        comm_after = comm_q;
        if (commit && commit_hit) comm_after[commit_idx] = 1'b1;

        // Committed entries surviving this edge (prefix after the drain).
        ccount = '0;
        for (int i = 0; i < N; i++) begin
            if (CNTW'(i) < count_q && comm_after[head_q + PTRW'(i)]) ccount = ccount + CNTW'(1);
        end
        if (drain) ccount = ccount - CNTW'(1);

        store_ok = store && !tlb_exception && !flush;
`ifdef STORE_BUFFER_COALESCE_EN
        merge = store_ok && !empty && !comm_after[yidx] && addr_q[yidx] == req_waddr;
`else
        merge = 1'b0;
`endif
        // full is the pre-edge value: a same-cycle drain does not free a slot.
        alloc = store_ok && !full && !merge;

        comm_d = comm_after;
        if (drain) comm_d[head_q] = 1'b0;
        if (alloc) comm_d[tail_q] = 1'b0;

        head_d = head_q + PTRW'(drain);
        if (flush) begin
            tail_d  = head_d + ccount[PTRW-1:0];
            count_d = ccount;
        end else begin
            tail_d  = tail_q + PTRW'(alloc);
            count_d = count_q - CNTW'(drain) + CNTW'(alloc);
        end
    end

    // Forwarding: walk old to young so the youngest writer of each lane wins.
    always_comb begin
        fwd_lanes = '0;
        fwd_found = '0;
        for (int i = 0; i < N; i++) begin
            if (CNTW'(i) < count_q && addr_q[head_q + PTRW'(i)] == req_waddr) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (mask_q[head_q + PTRW'(i)][b]) begin
                        fwd_lanes[b*8 +: 8] = data_q[head_q + PTRW'(i)][b*8 +: 8];
                        fwd_found[b]        = 1'b1;
                    end
                end
            end
        end
        fwd_hit         = fwd_found & req_mask;
        bypass_needed   = !store && (fwd_hit != '0);
        bypass_possible = !store && (fwd_hit == req_mask);
        bypass_value    = bypass_possible ? ((fwd_lanes & expand(req_mask)) >> {req_off, 3'b000}) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            comm_q  <= '0;
            for (int i = 0; i < N; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                mask_q[i] <= '0;
                rob_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            comm_q  <= comm_d;
            if (alloc) begin
                addr_q[tail_q] <= req_waddr;
                data_q[tail_q] <= st_data;
                mask_q[tail_q] <= req_mask;
                rob_q[tail_q]  <= input_rob_id;
            end
            if (merge) begin
                data_q[yidx] <= (data_q[yidx] & ~expand(req_mask)) | st_data;
                mask_q[yidx] <= mask_q[yidx] | req_mask;
                rob_q[yidx]  <= input_rob_id;
            end
        end
    end
endmodule

// File: doc/store_merge_buffer.md
# store_merge_buffer

Parametrised, byte-lane store buffer between the memory stage and the data cache. It supersedes the single-size FIFO with:
- byte, half-word and word stores tracked as per-lane byte masks;
- youngest-wins per-byte load forwarding, including partial-coverage detection;
- a valid/ack drain handshake to the cache;
- ROB-ordered commit and a flush of speculative entries.

## Interface
- N, 8, entry count, power of two ≥ 2
- WORD_SIZE, 32, data width in bits, multiple of 8 (BYTES = WORD_SIZE/8)
- WIDTH, 32, physical address width
- ROB_ENTRY_WIDTH, 4, ROB id width
- clk  in  1  clock, rising edge
- rst  in  1  reset rst, synchronous, active-high
- store  in  1  allocate request (store instruction, stage not stalled)
- tlb_exception  in  1  suppresses allocation this cycle
- physical_address  in  WIDTH  store address, or load address when store=0
- op_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- store_value  in  WORD_SIZE  right-aligned store data
- input_rob_id  in  ROB_ENTRY_WIDTH  ROB id of the allocating store
- commit  in  1  ROB grants the store commit_rob_id permission to write
- commit_rob_id  in  ROB_ENTRY_WIDTH  id being committed
- flush  in  1  discard all uncommitted entries
- cache_ack  in  1  cache accepted the current request
- cache_valid  out  1  head entry is committed and presented to the cache
- cache_address  out  WIDTH  word-aligned address (low log2(BYTES) bits zero)
- cache_data  out  WORD_SIZE  lane-positioned data
- cache_byte_mask  out  BYTES  lanes to write
- full  out  1  count == N
- empty  out  1  count == 0
- bypass_needed  out  1  load overlaps at least one buffered byte
- bypass_possible  out  1  every requested byte is buffered
- bypass_value  out  WORD_SIZE  forwarded data, right-aligned, zero-extended

## Operation
- Circular FIFO with head, tail and count (log2(N)+1 bits); wrap modulo N. Each entry holds word address, data, byte mask, rob_id and committed flag.
- Allocation on store & !full & !tlb_exception:
  - lane offset = physical_address[log2(BYTES)-1:0]; halves use offset with bit0 cleared;
  - byte mask = 1, 3 or all-ones, shifted left by offset;
  - data is shifted into the lane;
  - committed = 0.
- Commit: sets committed on the oldest valid entry with matching rob_id. A commit with no match is ignored.
- Commit order: commits arrive in program order, so committed entries always form a prefix starting at head.
- Drain: cache_valid = !empty & head.committed. Outputs are driven combinationally from head and held stable until cache_ack. On cache_valid & cache_ack, head advances and count decrements. cache_ack while !cache_valid is ignored.
- Flush: tail is set to head + committed-count; uncommitted entries are freed; committed entries are kept.
- Forwarding (combinational, evaluated when store=0):
  - per requested byte, search from head to tail; the youngest entry with matching word address and mask bit supplies that byte;
  - bypass_needed = any requested byte found;
  - bypass_possible = all requested bytes found;
  - bypass_value is valid only when bypass_possible=1; otherwise it is 0.
- Outputs while store=1: bypass_needed=0, bypass_possible=0, bypass_value=0.
- Reset values: all outputs are 0 except empty=1; head=tail=count=0; all committed flags and masks are 0.

## Timing
- Allocation, commit, drain and flush all take effect at the same rising edge.
- full and empty are combinational from the pre-edge count.
- Forwarding uses only pre-edge state. A store allocating in the same cycle is never forwarded.
- When full, a store is refused even if a drain completes in the same cycle.
- Precedence within one edge: drain, then commit, then flush, then allocate.
  - Flush in the same cycle as store: the allocation is dropped.
  - Commit together with flush: the commit is applied first, so that entry survives the flush.
  - Ack together with flush: the head drain still completes.
- rst mid-drain: the pending request is abandoned and cache_valid drops in the next cycle.
- Latency:
  - a store is forwardable 1 cycle after allocation;
  - it is drainable 1 cycle after commit;
  - minimum residency is 2 cycles.

## Configuration
- STORE_BUFFER_COALESCE_EN
- Defined: an allocating store whose word address equals the youngest entry's word address, where that entry is uncommitted, merges into that entry instead of allocating. The new data wins on overlapping lanes, masks are OR-ed, and rob_id is updated to the new store's id. Count is unchanged, so the merge is accepted even when full.
- Undefined: every accepted store allocates a new entry.

## Test plan
- Reset, then word store 0xDEADBEEF at 0x100 (rob 3): empty 1→0, count=1, cache_valid=0. Byte load 0x102: needed=1, possible=1, value=0x000000AD.
- Byte store 0x11 at 0x201, then word load 0x200: needed=1, possible=0. Word store 0x22 to 0x200 followed by byte load 0x200 returns 0x22 (youngest wins).
- Commit rob 3; cache_ack held low for 3 cycles: cache_valid=1 with address 0x100, mask 0xF, data stable throughout. Ack: empty=1 on the next cycle.
- Fill N=8 entries; with full=1, store plus ack in the same cycle: store refused, count=7; wrap sequence of 20 stores drains in order.
- Four stores, first two committed, flush: count=2, tail=head+2; a new store in the flush cycle is dropped.
- COALESCE_EN: half 0xBBAA at 0x300 then byte 0xCC at 0x301: one entry, mask 0x3, data 0x0000CCAA. Without the macro: two entries.
